// File: rtl/spike_window_counter.sv
// Spike-rate decoder: counts spikes over a programmable window of enabled cycles, results go out on a valid/ack handshake.
// Optional first-spike latency capture is built when SPIKE_LATENCY_EN is defined.
module spike_window_counter #(
    parameter int COUNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  spike,
    input  logic [2:0]            window_log2,
    input  logic                  count_ack,
    output logic [COUNT_BITS-1:0] count,
    output logic                  count_valid,
    output logic                  saturated,
    output logic                  overrun,
    output logic [10:0]           first_spike
);

    localparam logic [COUNT_BITS-1:0] ACC_MAX = {COUNT_BITS{1'b1}};
    localparam logic [COUNT_BITS-1:0] ACC_ONE = {{(COUNT_BITS-1){1'b0}}, 1'b1};

    logic [2:0]            win_cfg_r;
    logic [9:0]            cyc_cnt_r;
    logic [COUNT_BITS-1:0] acc_r;
    logic [9:0]            win_len_m1_s;
    logic                  win_last_s;
    logic [COUNT_BITS-1:0] acc_inc_s;

    // Window length decode, window-end detect and saturating accumulator increment.
    always_comb begin
        win_len_m1_s = 10'd7;
        case (win_cfg_r)
            3'd0:    win_len_m1_s = 10'd7;
            3'd1:    win_len_m1_s = 10'd15;
            3'd2:    win_len_m1_s = 10'd31;
            3'd3:    win_len_m1_s = 10'd63;
            3'd4:    win_len_m1_s = 10'd127;
            3'd5:    win_len_m1_s = 10'd255;
            3'd6:    win_len_m1_s = 10'd511;
            3'd7:    win_len_m1_s = 10'd1023;
            default: win_len_m1_s = 10'd7;
        endcase
        win_last_s = enable && (cyc_cnt_r == win_len_m1_s);
        if (spike && (acc_r != ACC_MAX)) begin
            acc_inc_s = acc_r + ACC_ONE;
        end else begin
            acc_inc_s = acc_r;
        end
    end

    // Cycle counter, accumulator and window configuration; the config only changes at a window boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt_r <= 10'd0;
            acc_r     <= {COUNT_BITS{1'b0}};
            win_cfg_r <= window_log2;
        end else if (win_last_s) begin
            cyc_cnt_r <= 10'd0;
            acc_r     <= {COUNT_BITS{1'b0}};
            win_cfg_r <= window_log2;
        end else if (enable) begin
            cyc_cnt_r <= cyc_cnt_r + 10'd1;
            acc_r     <= acc_inc_s;
        end
    end

    // Result register and handshake; an ack coinciding with a window end counts as consumed, so no overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= {COUNT_BITS{1'b0}};
            count_valid <= 1'b0;
            saturated   <= 1'b0;
            overrun     <= 1'b0;
        end else if (win_last_s) begin
            count       <= acc_inc_s;
            saturated   <= (acc_inc_s == ACC_MAX);
            count_valid <= 1'b1;
            if (count_valid && !count_ack) begin
                overrun <= 1'b1;
            end
        end else if (count_valid && count_ack) begin
            count_valid <= 1'b0;
        end
    end

`ifdef SPIKE_LATENCY_EN
    logic [10:0] fs_cap_r;
    logic [10:0] fs_next_s;

    // First spike of the window wins; the window-end spike is included via fs_next_s.
    always_comb begin
        if (spike && (fs_cap_r == 11'h7FF)) begin
            fs_next_s = {1'b0, cyc_cnt_r};
        end else begin
            fs_next_s = fs_cap_r;
        end
    end

    // Capture register and its latched copy on the result side.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_cap_r    <= 11'h7FF;
            first_spike <= 11'h7FF;
        end else if (win_last_s) begin
            first_spike <= fs_next_s;
            fs_cap_r    <= 11'h7FF;
        end else if (enable) begin
            fs_cap_r <= fs_next_s;
        end
    end
`else
    assign first_spike = 11'h7FF;
`endif

endmodule
